cpu_io_control: RTL and testbench

- Bus-side companion of the CPU control state machine: decodes the 4-bit cpu_state, runs single external read/write transactions on the memory bus, and returns a one-cycle ready pulse.
- Drives instruction fetch, operand load and result store; captures the fetched instruction and loaded data into holding registers for the datapath.
- Adds a wait-state timeout so a dead bus cannot hang the CPU.

---
 rtl/cpu_io_control.sv | 194 +++++++++++++++++++
 tb/tb_cpu_io_control.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_io_control.sv
// -----------------------------------------------------------------------------
// cpu_io_control
//   Bus-side companion of the CPU control state machine. Decodes cpu_state,
//   runs one external read or write transaction per begin state, captures
//   fetched instructions and loaded operands, and returns a one-cycle ready
//   pulse. A wait-state timeout aborts a transaction on a dead bus.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   reset      in   synchronous, active-low reset
//   cpu_state  in   4-bit state from CPU control
//   pc         in   fetch address
//   data_addr  in   load/store address
//   store_data in   store write data
//   mem_rdata  in   bus read data, valid with mem_ack
//   mem_ack    in   bus completion strobe
//   mem_addr   out  registered bus address
//   mem_wdata  out  registered bus write data
//   mem_req    out  registered bus request
//   mem_we     out  registered write enable (1 = store)
//   ready      out  one-cycle completion pulse to CPU control
//   instr      out  last fetched instruction
//   load_data  out  last loaded operand
//   bus_err    out  sticky timeout flag
// -----------------------------------------------------------------------------
module cpu_io_control #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        cpu_state,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic              ready,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] load_data,
    output logic              bus_err
);

    // CPU control state encoding
    typedef enum logic [3:0] {
        FETCH_BEGIN = 4'd0,
        FETCH_IO    = 4'd1,
        FETCH_END   = 4'd2,
        EXEC_BEGIN  = 4'd3,
        LOAD_BEGIN  = 4'd4,
        LOAD_IO     = 4'd5,
        LOAD_END    = 4'd6,
        CALC        = 4'd7,
        STORE_BEGIN = 4'd8,
        STORE_IO    = 4'd9
    } cpu_state_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t            state, state_nxt;
    kind_t             kind, kind_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              start;

    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              mem_req_nxt;
    logic              mem_we_nxt;
    logic              ready_nxt;
    logic [DATA_W-1:0] instr_nxt;
    logic [DATA_W-1:0] load_data_nxt;
    logic              bus_err_nxt;

    // Only the three begin states open a transaction; everything else,
    // including io states and unused codes 10-15, is a no-op in IDLE.
    always_comb begin
        start = 1'b0;
        case (cpu_state)
            FETCH_BEGIN, LOAD_BEGIN, STORE_BEGIN: start = 1'b1;
            default:                              start = 1'b0;
        endcase
    end

    // State register; every output is a flop loaded from its *_nxt value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            kind      <= K_FETCH;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            ready     <= 1'b0;
            instr     <= '0;
            load_data <= '0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            kind      <= kind_nxt;
            cnt       <= cnt_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            ready     <= ready_nxt;
            instr     <= instr_nxt;
            load_data <= load_data_nxt;
            bus_err   <= bus_err_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (mem_ack || (cnt == TMO)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        kind_nxt      = kind;
        cnt_nxt       = cnt;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        ready_nxt     = 1'b0;
        instr_nxt     = instr;
        load_data_nxt = load_data;
        bus_err_nxt   = bus_err;

        case (state)
            IDLE: begin
                if (start) begin
                    cnt_nxt     = '0;
                    mem_req_nxt = 1'b1;
                    case (cpu_state)
                        FETCH_BEGIN: begin
                            kind_nxt     = K_FETCH;
                            mem_addr_nxt = pc;
                            mem_we_nxt   = 1'b0;
                        end
                        LOAD_BEGIN: begin
                            kind_nxt     = K_LOAD;
                            mem_addr_nxt = data_addr;
                            mem_we_nxt   = 1'b0;
                        end
                        default: begin
                            kind_nxt      = K_STORE;
                            mem_addr_nxt  = data_addr;
                            mem_wdata_nxt = store_data;
                            mem_we_nxt    = 1'b1;
                        end
                    endcase
                end
            end
            BUSY: begin
                // An ack on the final allowed cycle still completes normally.
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    ready_nxt   = 1'b1;
                    if (kind == K_FETCH) instr_nxt     = mem_rdata;
                    if (kind == K_LOAD)  load_data_nxt = mem_rdata;
                end else if (cnt == TMO) begin
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    ready_nxt   = 1'b1;
                    bus_err_nxt = 1'b1;
                    if (kind == K_FETCH) instr_nxt     = '0;
                    if (kind == K_LOAD)  load_data_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_io_control.sv
module tb_cpu_io_control;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cpu_state;
    logic [15:0] pc, data_addr, store_data, mem_rdata;
    logic        mem_ack;
    logic [15:0] mem_addr, mem_wdata, instr, load_data;
    logic        mem_req, mem_we, ready, bus_err;

    cpu_io_control #(
        .ADDR_W (16),
        .DATA_W (16),
        .TIMEOUT(TMO),
        .CNT_W  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_state (cpu_state),
        .pc        (pc),
        .data_addr (data_addr),
        .store_data(store_data),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .ready     (ready),
        .instr     (instr),
        .load_data (load_data),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model of architecturally visible state
    logic [15:0] m_instr, m_load, m_addr, m_wdata;
    logic        m_err;

    typedef struct {
        string       name;
        int          kind;      // 0 fetch, 1 load, 2 store
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          waits;     // ack on req cycle waits+1; > TMO means never
        int          exp_req;
        logic [15:0] exp_instr;
        logic [15:0] exp_load;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input string nm, input int kind, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] rdata,
                           input int waits, input int exp_req,
                           input logic [15:0] exp_instr, input logic [15:0] exp_load,
                           input logic exp_err);
        int          reqcnt = 0;
        int          cyc    = 0;
        bit          bus_ok = 1'b1;
        bit          done   = 1'b0;
        logic [15:0] exp_wd;
        exp_wd = (kind == 2) ? wdata : m_wdata;

        cpu_state  = (kind == 0) ? 4'd0 : (kind == 1) ? 4'd4 : 4'd8;
        pc         = (kind == 0) ? addr : ~addr;
        data_addr  = (kind == 0) ? ~addr : addr;
        store_data = (kind == 2) ? wdata : 16'($urandom);
        mem_ack    = 1'b0;
        tick();
        // Inputs after the begin edge must not matter
        cpu_state  = (kind == 0) ? 4'd1 : (kind == 1) ? 4'd5 : 4'd9;
        pc         = 16'($urandom);
        data_addr  = 16'($urandom);
        store_data = 16'($urandom);

        while (!done && cyc < TMO + 10) begin
            cyc++;
            if (ready) done = 1'b1;
            if (mem_req) begin
                reqcnt++;
                if (mem_addr !== addr || mem_we !== (kind == 2) || mem_wdata !== exp_wd)
                    bus_ok = 1'b0;
            end
            mem_ack   = mem_req && (reqcnt == waits + 1);
            mem_rdata = mem_ack ? rdata : 16'($urandom);
            if (!done) tick();
        end
        chk({nm, "_ready_seen"}, 32'(done), 32'd1);
        chk({nm, "_req_cycles"}, 32'(reqcnt), 32'(exp_req));
        chk({nm, "_bus_fields"}, 32'(bus_ok), 32'd1);
        chk({nm, "_req_drop"},   32'({mem_req, mem_we}), 32'd0);
        chk({nm, "_addr_hold"},  32'(mem_addr), 32'(addr));
        chk({nm, "_instr"},      32'(instr), 32'(exp_instr));
        chk({nm, "_load_data"},  32'(load_data), 32'(exp_load));
        chk({nm, "_bus_err"},    32'(bus_err), 32'(exp_err));
        tick();
        chk({nm, "_ready_once"}, 32'({ready, mem_req}), 32'd0);
        cpu_state = (kind == 0) ? 4'd2 : (kind == 1) ? 4'd6 : 4'd7;
        tick();
        m_addr  = addr;
        m_wdata = exp_wd;
        m_instr = exp_instr;
        m_load  = exp_load;
        m_err   = exp_err;
    endtask

    // Random non-begin cycles with random acks: nothing may move.
    task automatic noise(input string nm, input int n);
        logic [3:0] nb[13] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd9,
                              4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        bit ok = 1'b1;
        repeat (n) begin
            cpu_state = nb[$urandom_range(0, 12)];
            mem_ack   = 1'($urandom);
            mem_rdata = 16'($urandom);
            pc        = 16'($urandom);
            data_addr = 16'($urandom);
            tick();
            if (mem_req || ready || mem_we || instr !== m_instr || load_data !== m_load ||
                mem_addr !== m_addr || mem_wdata !== m_wdata || bus_err !== m_err)
                ok = 1'b0;
        end
        mem_ack = 1'b0;
        chk(nm, 32'(ok), 32'd1);
    endtask

    initial begin
        vecs[0] = '{"fetch0",   0, 16'h0040, 16'h0000, 16'h1234, 0, 1, 16'h1234, 16'h0000, 1'b0};
        vecs[1] = '{"load3",    1, 16'h0100, 16'h0000, 16'hBEEF, 3, 4, 16'h1234, 16'hBEEF, 1'b0};
        vecs[2] = '{"store1",   2, 16'h0200, 16'h5A5A, 16'h0000, 1, 2, 16'h1234, 16'hBEEF, 1'b0};
        vecs[3] = '{"load_tmo", 1, 16'h0300, 16'h0000, 16'h7777, 9, 5, 16'h1234, 16'h0000, 1'b1};
        vecs[4] = '{"fetch_last", 0, 16'h0042, 16'h0000, 16'hCAFE, 4, 5, 16'hCAFE, 16'h0000, 1'b1};

        reset = 1'b0; cpu_state = 4'd7; pc = '0; data_addr = '0;
        store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
        m_instr = '0; m_load = '0; m_addr = '0; m_wdata = '0; m_err = 1'b0;
        repeat (3) tick();
        chk("reset_outputs",
            32'(|{mem_addr, mem_wdata, mem_req, mem_we, ready, instr, load_data, bus_err}), 32'd0);
        reset = 1'b1;
        tick();

        noise("io_without_begin", 6);

        for (int i = 0; i < 5; i++)
            run_txn(vecs[i].name, vecs[i].kind, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                    vecs[i].waits, vecs[i].exp_req, vecs[i].exp_instr, vecs[i].exp_load,
                    vecs[i].exp_err);

        // Sticky error survives a clean fetch
        run_txn("fetch_after_err", 0, 16'h0050, 16'h0000, 16'h4321, 0, 1,
                16'h4321, 16'h0000, 1'b1);

        // Spurious ack during calc
        cpu_state = 4'd7; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        repeat (3) tick();
        chk("spurious_ack", 32'({ready, mem_req}), 32'd0);
        chk("spurious_keep", 32'({instr, load_data}), {16'h4321, 16'h0000});
        mem_ack = 1'b0;

        // Reset during the second wait cycle of a fetch
        cpu_state = 4'd0; pc = 16'h0077;
        tick();
        cpu_state = 4'd1;
        tick();
        chk("mid_req_high", 32'(mem_req), 32'd1);
        reset = 1'b0;
        tick();
        chk("mid_reset_zero",
            32'(|{mem_addr, mem_wdata, mem_req, mem_we, ready, instr, load_data, bus_err}), 32'd0);
        reset = 1'b1; cpu_state = 4'd7; mem_ack = 1'b1;
        tick();
        chk("mid_no_ready", 32'({ready, mem_req}), 32'd0);
        mem_ack = 1'b0;
        m_instr = '0; m_load = '0; m_addr = '0; m_wdata = '0; m_err = 1'b0;
        run_txn("fetch_post_reset", 0, 16'h0010, 16'h0000, 16'hA5A5, 1, 2,
                16'hA5A5, 16'h0000, 1'b0);

        // Randomized transactions against the transaction-level model
        for (int t = 0; t < 40; t++) begin
            int          k, w, er;
            bit          tmo;
            logic [15:0] a, wd, rd, ei, el;
            k   = int'($urandom_range(0, 2));
            w   = int'($urandom_range(0, TMO + 2));
            a   = 16'($urandom);
            wd  = 16'($urandom);
            rd  = 16'($urandom);
            tmo = (w > TMO);
            er  = tmo ? TMO + 1 : w + 1;
            ei  = m_instr;
            el  = m_load;
            if (k == 0) ei = tmo ? 16'h0 : rd;
            if (k == 1) el = tmo ? 16'h0 : rd;
            run_txn($sformatf("rnd%0d", t), k, a, wd, rd, w, er, ei, el, m_err | tmo);
            noise($sformatf("rnd%0d_idle", t), 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
